// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM states, fetch payload, constants.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // IDLE: nothing outstanding; WAIT: response wanted; DROP: response to be discarded
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } fetch_state_t;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    // Instruction addresses are word aligned; low two bits are forced to zero
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer in front of it.
module if_id_reg
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            in_valid,
    input  fetch_word_t     in_word,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic            valid,
    output logic            skid_full,
    output logic            skid_free_c
);

    fetch_word_t skid_q;
    fetch_word_t skid_d;
    logic        skid_d_valid;
    logic        id_load_c;
    fetch_word_t id_word_c;
    logic        id_valid_d;
    logic        load_c;

    // IF/ID accepts a new entry when empty or when decode is moving
    assign load_c = !valid || !stall;

    // After a delivery, the skid stays empty only if the register was loadable and skid was empty
    assign skid_free_c = load_c && !skid_full;

    // Select IF/ID source (skid first, preserving order) and decide skid contents
    always_comb begin
        skid_d       = skid_q;
        skid_d_valid = skid_full;
        id_load_c    = 1'b0;
        id_word_c    = skid_q;
        id_valid_d   = valid;

        if (flush) begin
            skid_d_valid = 1'b0;
            id_valid_d   = 1'b0;
        end else if (load_c) begin
            if (skid_full) begin
                id_load_c    = 1'b1;
                id_word_c    = skid_q;
                id_valid_d   = 1'b1;
                skid_d       = in_word;
                skid_d_valid = in_valid;
            end else if (in_valid) begin
                id_load_c    = 1'b1;
                id_word_c    = in_word;
                id_valid_d   = 1'b1;
            end else begin
                id_valid_d   = 1'b0;
            end
        end else if (in_valid) begin
            skid_d       = in_word;
            skid_d_valid = 1'b1;
        end
    end

    // Skid buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q    <= '0;
            skid_full <= 1'b0;
        end else begin
            skid_q    <= skid_d;
            skid_full <= skid_d_valid;
        end
    end

    // IF/ID register; pc4 is precomputed so decode sees it registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            pc4   <= PC_STEP;
            valid <= 1'b0;
        end else begin
            valid <= id_valid_d;
            if (id_load_c) begin
                instr <= id_word_c.instr;
                pc    <= id_word_c.pc;
                pc4   <= id_word_c.pc + PC_STEP;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM feeding an IF/ID register with skid.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] target_c;
    logic            can_issue_c;
    logic            deliver_c;
    logic            req_c;
    logic [XLEN-1:0] addr_c;
    logic            skid_full;
    logic            skid_free_c;
    fetch_word_t     deliver_word_c;

    assign pc_plus4_c  = pc_q + PC_STEP;
    assign target_c    = align_pc(redirect_pc_i);
    assign can_issue_c = !skid_full && !redirect_i;

    assign deliver_word_c.instr = imem_rdata_i;
    assign deliver_word_c.pc    = pc_q;

    // Fetch FSM state and PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC, request and delivery decisions
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        deliver_c = 1'b0;
        req_c     = 1'b0;
        addr_c    = pc_q;

        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d = target_c;
                end else if (can_issue_c) begin
                    req_c   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    // Outstanding word belongs to the squashed path
                    pc_d    = target_c;
                    state_d = imem_rvalid_i ? IDLE : DROP;
                end else if (imem_rvalid_i) begin
                    deliver_c = 1'b1;
                    pc_d      = pc_plus4_c;
                    if (skid_free_c) begin
                        // Back-to-back: next request leaves in the same cycle
                        req_c  = 1'b1;
                        addr_c = pc_plus4_c;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_i) begin
                    pc_d = target_c;
                end
                if (imem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request is held low while reset is asserted so the first issue follows release
    assign imem_req_o  = req_c & rst_n;
    assign imem_addr_o = addr_c;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_i),
        .stall       (stall_i),
        .in_valid    (deliver_c),
        .in_word     (deliver_word_c),
        .instr       (if_id_instr_o),
        .pc          (if_id_pc_o),
        .pc4         (if_id_pc4_o),
        .valid       (if_id_valid_o),
        .skid_full   (skid_full),
        .skid_free_c (skid_free_c)
    );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall_i  input  1  decode stall; IF/ID register holds while asserted.
REQ-005 redirect_i  input  1  branch/jump taken, flush and refetch.
REQ-006 redirect_pc_i  input  32  redirect target; bits [1:0] ignored, treated as 00.
REQ-007 imem_req_o  output  1  one-cycle fetch request pulse.
REQ-008 imem_addr_o  output  32  fetch address, valid when imem_req_o=1.
REQ-009 imem_rvalid_i  input  1  response strobe, 1+ cycles after request.
REQ-010 imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-011 if_id_instr_o  output  32  instruction to decode/immediate generator.
REQ-012 if_id_pc_o  output  32  PC of if_id_instr_o.
REQ-013 if_id_pc4_o  output  32  if_id_pc_o + 4, mod 2^32.
REQ-014 if_id_valid_o  output  1  IF/ID entry holds a live instruction.

Function
REQ-015 Fetch PC register (pc) shall hold the next address to request.
REQ-016 At most one memory request shall be outstanding.
REQ-017 FSM states: IDLE (no request outstanding), WAIT (request outstanding, response wanted), DROP (request outstanding, response to be discarded).
REQ-018 can_issue = skid empty AND redirect_i=0.
REQ-019 IDLE: if can_issue, assert imem_req_o with imem_addr_o=pc and go to WAIT; otherwise stay.
REQ-020 WAIT, imem_rvalid_i=1, redirect_i=0: deliver {imem_rdata_i, pc}; pc<=pc+4; reissue the same cycle at pc+4 if a skid slot is still free after delivery (back-to-back), else go to IDLE.
REQ-021 WAIT, redirect_i=1, imem_rvalid_i=0: pc<=redirect_pc_i; go to DROP.
REQ-022 WAIT, redirect_i=1 and imem_rvalid_i=1 together: discard response; pc<=redirect_pc_i; go to IDLE.
REQ-023 DROP: on imem_rvalid_i discard data and go to IDLE; redirect_i in DROP only updates pc.
REQ-024 IDLE, redirect_i=1: pc<=redirect_pc_i, no request that cycle.
REQ-025 IF/ID register loads when if_id_valid_o=0 OR stall_i=0; source is skid if full, else delivered word.
REQ-026 Delivered word not loadable into IF/ID shall be written to the one-entry skid buffer.
REQ-027 Skid full and IF/ID loading: skid drains into IF/ID; new delivered word then refills skid in the same cycle.
REQ-028 IF/ID loading with nothing available: if_id_valid_o<=0.
REQ-029 redirect_i=1 shall clear if_id_valid_o and skid valid next cycle, overriding stall_i.
REQ-030 Instruction order to decode shall equal fetch order; no word dropped except on redirect.
REQ-031 Fetch-to-IF/ID latency: IF/ID updates on the edge imem_rvalid_i is sampled, unstalled.
REQ-032 pc arithmetic is 32-bit unsigned, wrapping 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-033 rst_n=0 shall asynchronously force: state IDLE, pc=RESET_PC, skid empty.
REQ-034 Reset values: imem_req_o=0, imem_addr_o=RESET_PC, if_id_instr_o=32'h0000_0013 (NOP), if_id_pc_o=0, if_id_pc4_o=4, if_id_valid_o=0.
REQ-035 Response arriving after mid-request reset shall be ignored (state IDLE, no request pending).
REQ-036 First request shall be issued on the first rising edge after rst_n deasserts.

Structure
REQ-037 Shared package rv32i_pkg: fetch_state_t enum {IDLE, WAIT, DROP}, NOP_INSTR=32'h0000_0013, default RESET_PC.
REQ-038 One sub-module, if_id_reg: IF/ID register plus skid buffer, load/flush controls.
REQ-039 imem_req_o and imem_addr_o combinational from state, pc, skid and redirect_i.

Verification
REQ-040 Reset release, 1-cycle memory returning 32'h00500093 at 0x0 -> req at 0x0, IF/ID {00500093, pc 0, pc4 4, valid 1}, next req 0x4.
REQ-041 stall_i high 3 cycles with responses continuing -> IF/ID holds, skid holds next word, no request while skid full, order preserved after release.
REQ-042 redirect_i to 0x0000_0102 while WAIT -> DROP, stale rdata discarded, next req 0x0000_0100, if_id_valid_o=0 meanwhile.
REQ-043 redirect_i and imem_rvalid_i same cycle -> data discarded, IDLE, req at target next cycle.
REQ-044 pc 0xFFFF_FFFC fetched -> next req 0x0000_0000, if_id_pc4_o=0x0000_0000.
REQ-045 rst_n low while WAIT, late rvalid after release -> ignored, req at RESET_PC, outputs at reset values.
